// File: rtl/counter_capture_fifo_if.sv
// Capture-port bundle between the counter and its capture FIFO: trigger
// inputs, control, and the valid/ready drain side plus status outputs.
// Ports: master = producer/consumer (bench or system), slave = the FIFO block.
interface counter_capture_fifo_if #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int LANES = 8
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int DW = 2 + LANES + W;

  logic             cc_enable;
  logic             cc_clear;
  logic [LANES-1:0] cc_rco_mask;
  logic             cc_load_en;
  logic [W-1:0]     cc_Q;
  logic [LANES-1:0] cc_rco;
  logic [LANES-1:0] cc_load;
  logic             cc_out_valid;
  logic             cc_out_ready;
  logic [DW-1:0]    cc_out_data;
  logic [LW-1:0]    cc_level;
  logic             cc_overflow;
  logic [7:0]       cc_drop_cnt;

  modport master (
    output cc_enable, cc_clear, cc_rco_mask, cc_load_en, cc_Q, cc_rco, cc_load,
    output cc_out_ready,
    input  cc_out_valid, cc_out_data, cc_level, cc_overflow, cc_drop_cnt
  );

  modport slave (
    input  cc_enable, cc_clear, cc_rco_mask, cc_load_en, cc_Q, cc_rco, cc_load,
    input  cc_out_ready,
    output cc_out_valid, cc_out_data, cc_level, cc_overflow, cc_drop_cnt
  );
endinterface

// File: rtl/counter_capture_fifo.sv
// Purpose: snapshot the counter value into a FIFO on rco/load rising edges.
// Latency: captured entry reaches the head one cycle after the trigger cycle.
// Backpressure: valid/ready drain; full & ~pop drops the capture, sets sticky
// overflow and bumps a saturating 8-bit drop counter.
// Ports: cc_clk, cc_reset (async, active-low), bus (slave side of the bundle).
module counter_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int LANES = 8
) (
  input  logic                   cc_clk,
  input  logic                   cc_reset,
  counter_capture_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = 2 + LANES + W;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             ovf_q,    ovf_d;
  logic [7:0]       drop_q,   drop_d;
  logic [LANES-1:0] rco_q;
  logic [LANES-1:0] load_q;

  logic          rco_hit, load_hit;
  logic          push, pop, full, wr_en, drop;
  logic [DW-1:0] entry;

  always_comb begin
    rco_hit  = |(bus.cc_rco & ~rco_q & bus.cc_rco_mask);
    load_hit = bus.cc_load_en & (|(bus.cc_load & ~load_q));
    push     = bus.cc_enable & (rco_hit | load_hit) & ~bus.cc_clear;
    full     = (level_q == LW'(DEPTH));
    // Empty FIFO cannot pop, so a same-cycle push on empty is simply written.
    pop      = (level_q != '0) & bus.cc_out_ready & ~bus.cc_clear;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    entry    = {load_hit, rco_hit, bus.cc_rco, bus.cc_Q};

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (bus.cc_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge cc_clk or negedge cc_reset) begin
    if (!cc_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      rco_q    <= '0;
      load_q   <= '0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      // Edge history tracks the flags even while disabled or clearing, so
      // re-enabling with a flag already high does not fire a capture.
      rco_q    <= bus.cc_rco;
      load_q   <= bus.cc_load;
    end
  end

  assign bus.cc_out_valid = (level_q != '0);
  assign bus.cc_out_data  = mem_q[rd_ptr_q];
  assign bus.cc_level     = level_q;
  assign bus.cc_overflow  = ovf_q;
  assign bus.cc_drop_cnt  = drop_q;

endmodule

// File: tb/tb_counter_capture_fifo.sv
module tb_counter_capture_fifo;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int LANES = 8;
  localparam int DW    = 2 + LANES + W;

  logic cc_clk;
  logic cc_reset;
  int   n_checks;
  int   n_fail;

  counter_capture_fifo_if #(.DEPTH(DEPTH), .W(W), .LANES(LANES)) bus ();

  counter_capture_fifo #(.DEPTH(DEPTH), .W(W), .LANES(LANES)) dut (
    .cc_clk   (cc_clk),
    .cc_reset (cc_reset),
    .bus      (bus)
  );

  initial cc_clk = 1'b0;
  always #5 cc_clk = ~cc_clk;

  // Reference state: expected FIFO contents, occupancy and status.
  logic [DW-1:0]    exp_q[$];
  int               mdl_level;
  logic             mdl_ovf;
  int               mdl_drops;
  logic [LANES-1:0] prev_rco;
  logic [LANES-1:0] prev_load;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one capture decision per clock from the behavioural rules.
  always @(posedge cc_clk) begin
    if (!cc_reset) begin
      exp_q.delete();
      mdl_level = 0;
      mdl_ovf   = 1'b0;
      mdl_drops = 0;
      prev_rco  = '0;
      prev_load = '0;
    end else begin
      bit rh, lh, trig, popm;
      rh   = ((bus.cc_rco & ~prev_rco & bus.cc_rco_mask) != '0);
      lh   = bus.cc_load_en && ((bus.cc_load & ~prev_load) != '0);
      trig = bus.cc_enable && (rh || lh);
      if (bus.cc_clear) begin
        exp_q.delete();
        mdl_level = 0;
        mdl_ovf   = 1'b0;
        mdl_drops = 0;
      end else begin
        popm = (mdl_level > 0) && bus.cc_out_ready;
        if (trig) begin
          if (mdl_level < DEPTH || popm) begin
            exp_q.push_back({lh, rh, bus.cc_rco, bus.cc_Q});
            mdl_level++;
          end else begin
            mdl_ovf = 1'b1;
            if (mdl_drops < 255) mdl_drops++;
          end
        end
        if (popm) mdl_level--;
      end
      prev_rco  = bus.cc_rco;
      prev_load = bus.cc_load;
    end
  end

  // Monitor: compare status every cycle and the head entry whenever valid;
  // a head that will be accepted at the next edge is retired from the queue.
  always @(negedge cc_clk) begin
    if (cc_reset) begin
      check("level",    64'(bus.cc_level),     64'(mdl_level));
      check("valid",    64'(bus.cc_out_valid), 64'(mdl_level != 0));
      check("overflow", 64'(bus.cc_overflow),  64'(mdl_ovf));
      check("drop_cnt", 64'(bus.cc_drop_cnt),  64'(mdl_drops));
      if (bus.cc_out_valid) begin
        if (exp_q.size() == 0) begin
          check("head_present", 64'(0), 64'(1));
        end else begin
          check("head_data", 64'(bus.cc_out_data), 64'(exp_q[0]));
          if (bus.cc_out_ready && !bus.cc_clear) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge cc_clk);
    #2;
  endtask

  task automatic rco_edge(input logic [LANES-1:0] lanes, input logic [W-1:0] q);
    bus.cc_rco = '0;
    cyc();
    bus.cc_rco = lanes;
    bus.cc_Q   = q;
    cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    64'(bus.cc_out_valid), 64'(0));
    check({tag, "_level"},    64'(bus.cc_level),     64'(0));
    check({tag, "_data"},     64'(bus.cc_out_data),  64'(0));
    check({tag, "_overflow"}, 64'(bus.cc_overflow),  64'(0));
    check({tag, "_drop_cnt"}, 64'(bus.cc_drop_cnt),  64'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cc_reset         = 1'b0;
    bus.cc_enable    = 1'b0;
    bus.cc_clear     = 1'b0;
    bus.cc_rco_mask  = '0;
    bus.cc_load_en   = 1'b0;
    bus.cc_Q         = '0;
    bus.cc_rco       = '0;
    bus.cc_load      = '0;
    bus.cc_out_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) cyc();
    cc_reset = 1'b1;
    cyc();

    // 1: single rco edge, visible one cycle later
    bus.cc_enable   = 1'b1;
    bus.cc_rco_mask = 8'hFF;
    bus.cc_rco      = 8'h01;
    bus.cc_Q        = 32'h0000000F;
    cyc();
    @(negedge cc_clk);
    check("t1_valid", 64'(bus.cc_out_valid), 64'(1));
    check("t1_data",  64'(bus.cc_out_data),  64'({2'b01, 8'h01, 32'h0000000F}));
    check("t1_level", 64'(bus.cc_level),     64'(1));

    // 2: held flag is edge-only
    repeat (5) cyc();
    check("t2_level", 64'(bus.cc_level), 64'(1));

    // 3: overflow with six edges into an empty FIFO, then drain
    bus.cc_clear = 1'b1;
    cyc();
    bus.cc_clear = 1'b0;
    for (int i = 0; i < 6; i++) rco_edge(8'h01, 32'(100 + i));
    @(negedge cc_clk);
    check("t3_level",    64'(bus.cc_level),    64'(4));
    check("t3_overflow", 64'(bus.cc_overflow), 64'(1));
    check("t3_drop_cnt", 64'(bus.cc_drop_cnt), 64'(2));
    check("t3_head_q",   64'(bus.cc_out_data[W-1:0]), 64'(100));
    bus.cc_out_ready = 1'b1;
    repeat (4) cyc();
    bus.cc_out_ready = 1'b0;

    // 4: full FIFO, push and pop together
    for (int i = 0; i < 4; i++) rco_edge(8'h01, 32'(200 + i));
    bus.cc_rco = '0;
    cyc();
    bus.cc_rco       = 8'h01;
    bus.cc_Q         = 32'(300);
    bus.cc_out_ready = 1'b1;
    cyc();
    bus.cc_out_ready = 1'b0;
    @(negedge cc_clk);
    check("t4_level",    64'(bus.cc_level),            64'(4));
    check("t4_drop_cnt", 64'(bus.cc_drop_cnt),         64'(2));
    check("t4_head_q",   64'(bus.cc_out_data[W-1:0]),  64'(201));
    bus.cc_out_ready = 1'b1;
    repeat (4) cyc();
    bus.cc_out_ready = 1'b0;

    // 5: coincident load and rco edges
    bus.cc_rco     = '0;
    bus.cc_load    = '0;
    bus.cc_load_en = 1'b1;
    cyc();
    bus.cc_rco  = 8'h08;
    bus.cc_load = 8'h08;
    bus.cc_Q    = 32'hA5A5A5A5;
    cyc();
    @(negedge cc_clk);
    check("t5_data", 64'(bus.cc_out_data), 64'({2'b11, 8'h08, 32'hA5A5A5A5}));

    // 6: clear with trigger, then async reset mid-drain
    bus.cc_load = '0;
    rco_edge(8'h01, 32'(400));
    @(negedge cc_clk);
    check("t6_level", 64'(bus.cc_level), 64'(2));
    bus.cc_rco   = '0;
    cyc();
    bus.cc_rco   = 8'h01;
    bus.cc_clear = 1'b1;
    cyc();
    bus.cc_clear = 1'b0;
    @(negedge cc_clk);
    check("t6_clr_level",    64'(bus.cc_level),     64'(0));
    check("t6_clr_valid",    64'(bus.cc_out_valid), 64'(0));
    check("t6_clr_overflow", 64'(bus.cc_overflow),  64'(0));
    check("t6_clr_drop_cnt", 64'(bus.cc_drop_cnt),  64'(0));
    rco_edge(8'h01, 32'(500));
    rco_edge(8'h01, 32'(501));
    bus.cc_out_ready = 1'b1;
    cyc();
    cc_reset = 1'b0;
    #1;
    check_reset_outputs("t6_arst");
    cyc();
    cc_reset         = 1'b1;
    bus.cc_out_ready = 1'b0;
    bus.cc_rco       = '0;
    cyc();

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) bus.cc_rco  = LANES'($urandom);
      if ($urandom_range(0, 3) == 0) bus.cc_load = LANES'($urandom);
      if ($urandom_range(0, 15) == 0) bus.cc_rco_mask = LANES'($urandom);
      bus.cc_enable    = ($urandom_range(0, 7) != 0);
      bus.cc_load_en   = $urandom_range(0, 1) == 1;
      bus.cc_clear     = ($urandom_range(0, 63) == 0);
      bus.cc_out_ready = ($urandom_range(0, 2) == 0);
      bus.cc_Q         = $urandom;
      if (c == 1500) begin
        cc_reset = 1'b0;
        #1;
        check_reset_outputs("rnd_arst");
        cyc();
        cc_reset = 1'b1;
      end
      cyc();
    end

    bus.cc_enable = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
